// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - opcodes, frame lengths, FSM states and frame byte mux for the UART command master
package uart_cmd_pkg;

    localparam logic [7:0] CMD_WR   = 8'h01;
    localparam logic [7:0] CMD_RD   = 8'h02;
    localparam logic [7:0] ACK_BYTE = 8'hA5;

    localparam logic [2:0] WR_TX_BYTES  = 3'd6;
    localparam logic [2:0] RD_TX_BYTES  = 3'd4;
    localparam logic [1:0] WR_RSP_BYTES = 2'd1;
    localparam logic [1:0] RD_RSP_BYTES = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RSP,
        ST_DONE
    } state_t;

    // Request frame byte by index: opcode, address MSB first, then write data MSB first.
    function automatic logic [7:0] frame_byte(
        input logic        wr,
        input logic [23:0] addr,
        input logic [15:0] wdata,
        input logic [2:0]  idx
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = wr ? CMD_WR : CMD_RD;
            3'd1:    b = addr[23:16];
            3'd2:    b = addr[15:8];
            3'd3:    b = addr[7:0];
            3'd4:    b = wdata[15:8];
            default: b = wdata[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 UART byte receiver with input synchronizer and mid-bit sampling
module uart_byte_rx #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rxd_i,
    output logic       start_o,
    output logic       busy_o,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);

    localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 2;
    localparam logic [CW-1:0] FULL_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t   state_q;
    logic        sync1_q, sync2_q, prev_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  data_q;
    logic        valid_q, ferr_q;
    logic        fall;

    assign fall         = prev_q & ~sync2_q;
    assign start_o      = (state_q == RX_HUNT) & fall;
    assign busy_o       = (state_q != RX_HUNT);
    assign byte_valid_o = valid_q;
    assign byte_data_o  = data_q;
    assign frame_err_o  = ferr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= RX_HUNT;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rxd_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            valid_q <= 1'b0;
            case (state_q)
                RX_HUNT: begin
                    if (fall) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= sync2_q ? RX_HUNT : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q  <= '0;
                        data_q <= {sync2_q, data_q[7:1]};
                        bit_q  <= bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (cnt_q == FULL_LAST) begin
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                        ferr_q  <= ~sync2_q;
                        state_q <= RX_HUNT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_master.sv
// rtl/uart_cmd_master.sv - turns read/write requests into UART command frames and checks the response
module uart_cmd_master #(
    parameter int CLK_FREQ       = 50000000,
    parameter int BAUD           = 115200,
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [23:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        uart_txd,
    input  logic        uart_rxd
);

    import uart_cmd_pkg::*;

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 2;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state_q;
    logic          txd_q, ready_q, busy_q;
    logic          rsp_valid_q, rsp_err_q;
    logic [15:0]   rsp_rdata_q;
    logic          wr_q;
    logic [23:0]   addr_q;
    logic [15:0]   wdata_q;
    logic [BW-1:0] baud_cnt_q;
    logic [3:0]    bit_idx_q;
    logic [2:0]    byte_idx_q;
    logic [1:0]    rsp_cnt_q;
    logic [7:0]    rdata_hi_q;
    logic [TW-1:0] to_cnt_q;

    logic       rx_start, rx_busy, rx_valid, rx_ferr;
    logic [7:0] rx_data;

    logic [7:0] cur_byte;
    logic [2:0] last_byte;
    logic [1:0] rsp_need;
    logic       rx_active, timeout_hit;
    logic       fin_d, fin_err_d;
    logic [15:0] fin_data_d;

    uart_byte_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk_i       (sys_clk),
        .rst_i       (sys_rst),
        .rxd_i       (uart_rxd),
        .start_o     (rx_start),
        .busy_o      (rx_busy),
        .byte_valid_o(rx_valid),
        .byte_data_o (rx_data),
        .frame_err_o (rx_ferr)
    );

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign uart_txd  = txd_q;

    // A start bit seen this cycle beats a timeout expiring this cycle.
    assign rx_active   = rx_start | rx_busy;
    assign timeout_hit = ~rx_active & (to_cnt_q == TO_LAST);

    always_comb begin
        cur_byte   = frame_byte(wr_q, addr_q, wdata_q, byte_idx_q);
        last_byte  = (wr_q ? WR_TX_BYTES : RD_TX_BYTES) - 3'd1;
        rsp_need   = wr_q ? WR_RSP_BYTES : RD_RSP_BYTES;
        fin_d      = 1'b0;
        fin_err_d  = 1'b0;
        fin_data_d = 16'h0000;
        if (state_q == ST_WAIT_RSP) begin
            if (rx_valid) begin
                if (rx_ferr) begin
                    fin_d     = 1'b1;
                    fin_err_d = 1'b1;
                end else if (rsp_cnt_q == rsp_need - 2'd1) begin
                    fin_d      = 1'b1;
                    fin_err_d  = wr_q && (rx_data != ACK_BYTE);
                    fin_data_d = wr_q ? 16'h0000 : {rdata_hi_q, rx_data};
                end
            end else if (timeout_hit) begin
                fin_d     = 1'b1;
                fin_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            txd_q       <= 1'b1;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            baud_cnt_q  <= '0;
            bit_idx_q   <= '0;
            byte_idx_q  <= '0;
            rsp_cnt_q   <= '0;
            rdata_hi_q  <= '0;
            to_cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        wr_q       <= cmd_wr;
                        addr_q     <= cmd_addr;
                        wdata_q    <= cmd_wdata;
                        state_q    <= ST_SEND;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                        txd_q      <= 1'b0;
                        baud_cnt_q <= '0;
                        bit_idx_q  <= '0;
                        byte_idx_q <= '0;
                    end
                end
                ST_SEND: begin
                    if (baud_cnt_q == BAUD_LAST) begin
                        baud_cnt_q <= '0;
                        if (bit_idx_q == 4'd9) begin
                            if (byte_idx_q == last_byte) begin
                                state_q   <= ST_WAIT_RSP;
                                txd_q     <= 1'b1;
                                rsp_cnt_q <= '0;
                                to_cnt_q  <= '0;
                            end else begin
                                byte_idx_q <= byte_idx_q + 3'd1;
                                bit_idx_q  <= '0;
                                txd_q      <= 1'b0;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                            txd_q     <= (bit_idx_q == 4'd8) ? 1'b1 : cur_byte[bit_idx_q[2:0]];
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + 1'b1;
                    end
                end
                ST_WAIT_RSP: begin
                    to_cnt_q <= (rx_active || rx_valid) ? '0 : to_cnt_q + 1'b1;
                    if (fin_d) begin
                        state_q     <= ST_DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= fin_err_d;
                        rsp_rdata_q <= fin_err_d ? 16'h0000 : fin_data_d;
                    end else if (rx_valid) begin
                        rdata_hi_q <= rx_data;
                        rsp_cnt_q  <= rsp_cnt_q + 2'd1;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                    ready_q     <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule
